// File: rtl/dist_conv_pkg.sv
// Shared types and constants for the distance conversion datapath.
// Coefficients are unsigned Q2.16, rounded to nearest.
package dist_conv_pkg;

  typedef enum logic [1:0] {
    MODE_M2FT  = 2'd0,
    MODE_FT2M  = 2'd1,
    MODE_KM2MI = 2'd2,
    MODE_MI2KM = 2'd3
  } mode_e;

  localparam int unsigned COEF_W    = 18;
  localparam int unsigned COEF_FRAC = 16;

  localparam logic [COEF_W-1:0] COEF_M2FT  = 18'd215011; // 3.2808
  localparam logic [COEF_W-1:0] COEF_FT2M  = 18'd19975;  // 0.3048
  localparam logic [COEF_W-1:0] COEF_KM2MI = 18'd40722;  // 0.621371
  localparam logic [COEF_W-1:0] COEF_MI2KM = 18'd105470; // 1.609344

  function automatic logic [COEF_W-1:0] coef_of(input mode_e m);
    logic [COEF_W-1:0] c;
    case (m)
      MODE_M2FT:  c = COEF_M2FT;
      MODE_FT2M:  c = COEF_FT2M;
      MODE_KM2MI: c = COEF_KM2MI;
      MODE_MI2KM: c = COEF_MI2KM;
      default:    c = COEF_M2FT;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/round_sat.sv
// Combinational round-half-up and saturate: drops IN_FRAC-OUT_FRAC fraction
// bits from an unsigned product and clamps to OUT_W bits of all-ones.
module round_sat #(
  parameter int unsigned IN_W     = 34,
  parameter int unsigned IN_FRAC  = 24,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned OUT_FRAC = 8
) (
  input  logic [IN_W-1:0]  prod,
  output logic [OUT_W-1:0] out_data,
  output logic             sat
);

  localparam int unsigned SHIFT = IN_FRAC - OUT_FRAC;
  localparam int unsigned SUM_W = IN_W + 1;
  localparam int unsigned Q_W   = SUM_W - SHIFT;
  localparam logic [SUM_W-1:0] HALF = {{(SUM_W-1){1'b0}}, 1'b1} << (SHIFT - 1);

  logic [SUM_W-1:0] sum;
  logic [Q_W-1:0]   q;

  always_comb begin
    sum      = {1'b0, prod} + HALF;
    q        = Q_W'(sum >> SHIFT);
    sat      = |q[Q_W-1:OUT_W];
    out_data = sat ? '1 : q[OUT_W-1:0];
  end

endmodule

// File: rtl/distance_conv_pipe.sv
// Three-stage multiply / round / saturate distance converter with a single
// global stall (adv) shared by every stage and by the input handshake.
module distance_conv_pipe
  import dist_conv_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_mode,
  output logic              out_sat,
  output logic [CNT_W-1:0]  conv_count
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;

  logic              s1_v_q, s1_v_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  mode_e             s1_mode_q, s1_mode_d;
  logic [COEF_W-1:0] s1_coef_q, s1_coef_d;

  logic              s2_v_q, s2_v_d;
  logic [PROD_W-1:0] s2_prod_q, s2_prod_d;
  mode_e             s2_mode_q, s2_mode_d;

  logic              out_v_q, out_v_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  mode_e             out_mode_q, out_mode_d;
  logic              out_sat_q, out_sat_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              adv;
  logic [PROD_W-1:0] s1_prod;
  logic [DATA_W-1:0] rs_data;
  logic              rs_sat;

  assign s1_prod = PROD_W'(s1_data_q) * PROD_W'(s1_coef_q);

  round_sat #(
    .IN_W    (PROD_W),
    .IN_FRAC (FRAC_W + COEF_FRAC),
    .OUT_W   (DATA_W),
    .OUT_FRAC(FRAC_W)
  ) u_round_sat (
    .prod    (s2_prod_q),
    .out_data(rs_data),
    .sat     (rs_sat)
  );

  assign adv        = !out_v_q || out_ready;
  assign in_ready   = adv;
  assign out_valid  = out_v_q;
  assign out_data   = out_data_q;
  assign out_mode   = out_mode_q;
  assign out_sat    = out_sat_q;
  assign conv_count = cnt_q;

  // Valid bits always shift on adv (bubbles travel too); payload only loads
  // behind a valid so the output holds its last result between samples.
  always_comb begin
    s1_v_d     = s1_v_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s1_coef_d  = s1_coef_q;
    s2_v_d     = s2_v_q;
    s2_prod_d  = s2_prod_q;
    s2_mode_d  = s2_mode_q;
    out_v_d    = out_v_q;
    out_data_d = out_data_q;
    out_mode_d = out_mode_q;
    out_sat_d  = out_sat_q;
    cnt_d      = cnt_q;

    if (adv) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_mode_d = mode_e'(in_mode);
        s1_coef_d = coef_of(mode_e'(in_mode));
      end
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_prod_d = s1_prod;
        s2_mode_d = s1_mode_q;
      end
      out_v_d = s2_v_q;
      if (s2_v_q) begin
        out_data_d = rs_data;
        out_mode_d = s2_mode_q;
        out_sat_d  = rs_sat;
      end
    end

    if (out_v_q && out_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q     <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= MODE_M2FT;
      s1_coef_q  <= '0;
      s2_v_q     <= 1'b0;
      s2_prod_q  <= '0;
      s2_mode_q  <= MODE_M2FT;
      out_v_q    <= 1'b0;
      out_data_q <= '0;
      out_mode_q <= MODE_M2FT;
      out_sat_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s1_coef_q  <= s1_coef_d;
      s2_v_q     <= s2_v_d;
      s2_prod_q  <= s2_prod_d;
      s2_mode_q  <= s2_mode_d;
      out_v_q    <= out_v_d;
      out_data_q <= out_data_d;
      out_mode_q <= out_mode_d;
      out_sat_q  <= out_sat_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_distance_conv_pipe.sv
// Self-checking bench for distance_conv_pipe: vector table, directed
// handshake/reset/wrap sequences and random traffic against a scoreboard.
module tb_distance_conv_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mode;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_mode;
  logic        out_sat;
  logic [15:0] conv_count;

  distance_conv_pipe #(.DATA_W(16), .FRAC_W(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .out_sat   (out_sat),
    .conv_count(conv_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  mode;
    logic        sat;
    int          acc_edge;
  } exp_t;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  mode;
    logic        sat;
  } got_t;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] data;
    logic [15:0] exp_data;
    logic        exp_sat;
  } vec_t;

  exp_t        sb[$];
  got_t        got_q[$];
  logic [15:0] exp_cnt = '0;
  int          n_out = 0;
  int          cyc = 0;
  bit          chk_lat = 1'b0;
  bit          have_prev = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic [1:0]  prev_mode;
  logic        prev_sat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: value * factor, rounded half up, clamped to 16 bits.
  function automatic got_t model(input logic [1:0] m, input logic [15:0] d);
    longint unsigned c;
    longint unsigned r;
    got_t g;
    case (m)
      2'd0:    c = 215011;
      2'd1:    c = 19975;
      2'd2:    c = 40722;
      default: c = 105470;
    endcase
    r = (longint'(d) * c + 32768) / 65536;
    g.mode = m;
    if (r > 65535) begin
      g.data = 16'hFFFF;
      g.sat  = 1'b1;
    end else begin
      g.data = 16'(r);
      g.sat  = 1'b0;
    end
    return g;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_cnt   = '0;
      have_prev = 1'b0;
    end else begin
      got_t g;
      exp_t e;
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      chk("conv_count", conv_count, exp_cnt);
      if (have_prev && prev_stall) begin
        chk("stall_out_valid", out_valid, 1);
        chk("stall_out_data", out_data, prev_data);
        chk("stall_out_mode", out_mode, prev_mode);
        chk("stall_out_sat", out_sat, prev_sat);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_out_data", out_data, e.data);
          chk("sb_out_mode", out_mode, e.mode);
          chk("sb_out_sat", out_sat, e.sat);
          // result register loads on the third edge counting the accept edge
          if (chk_lat) chk("latency_edges", cyc - e.acc_edge, 2);
        end
        got_q.push_back('{out_data, out_mode, out_sat});
        exp_cnt = exp_cnt + 16'd1;
        n_out++;
      end
      if (in_valid && in_ready) begin
        g = model(in_mode, in_data);
        sb.push_back('{g.data, g.mode, g.sat, cyc + 1});
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_mode  = out_mode;
      prev_sat   = out_sat;
      have_prev  = 1'b1;
    end
  end

  task automatic send(input logic [1:0] m, input logic [15:0] d);
    bit acc;
    int t;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int t;
    bit done;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    t    = 0;
    done = 1'b0;
    while (!done && t < 40) begin
      @(negedge clk);
      #1;
      done = (sb.size() == 0) && !out_valid;
      t++;
    end
    if (!done) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[16];
    logic [15:0] il_exp[4];
    logic [15:0] vals[10];
    logic [1:0]  vmodes[10];
    int          t;
    int          idx;
    int          stalled;
    int          base;
    int          seen;
    bit          saw_low;
    bit          acc;

    tbl[0]  = '{2'd0, 16'd256,   16'd840,   1'b0};
    tbl[1]  = '{2'd0, 16'd768,   16'd2520,  1'b0};
    tbl[2]  = '{2'd0, 16'd2560,  16'd8399,  1'b0};
    tbl[3]  = '{2'd1, 16'd256,   16'd78,    1'b0};
    tbl[4]  = '{2'd0, 16'd25600, 16'hFFFF,  1'b1};
    tbl[5]  = '{2'd2, 16'd256,   16'd159,   1'b0};
    tbl[6]  = '{2'd3, 16'd256,   16'd412,   1'b0};
    tbl[7]  = '{2'd0, 16'd0,     16'd0,     1'b0};
    tbl[8]  = '{2'd3, 16'd0,     16'd0,     1'b0};
    tbl[9]  = '{2'd1, 16'hFFFF,  16'd19975, 1'b0};
    tbl[10] = '{2'd3, 16'hFFFF,  16'hFFFF,  1'b1};
    tbl[11] = '{2'd2, 16'hFFFF,  16'd40721, 1'b0};
    tbl[12] = '{2'd1, 16'd32768, 16'd9988,  1'b0};
    tbl[13] = '{2'd0, 16'd19975, 16'd65534, 1'b0};
    tbl[14] = '{2'd0, 16'd19976, 16'hFFFF,  1'b1};
    tbl[15] = '{2'd2, 16'd32768, 16'd20361, 1'b0};
    il_exp[0] = 16'd840;
    il_exp[1] = 16'd78;
    il_exp[2] = 16'd159;
    il_exp[3] = 16'd412;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 2'd0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_mode", out_mode, 0);
    chk("reset_out_sat", out_sat, 0);
    chk("reset_conv_count", conv_count, 0);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Streamed metres-to-feet samples
    chk_lat   = 1'b1;
    out_ready = 1'b1;
    got_q.delete();
    send(2'd0, 16'd256);
    send(2'd0, 16'd768);
    send(2'd0, 16'd2560);
    drain();
    chk("stream_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("stream_0", got_q[0].data, 840);
      chk("stream_1", got_q[1].data, 2520);
      chk("stream_2", got_q[2].data, 8399);
      chk("stream_sat", {got_q[0].sat, got_q[1].sat, got_q[2].sat}, 0);
    end
    chk("stream_conv_count", conv_count, 3);

    // Vector table, one sample at a time
    foreach (tbl[i]) begin
      send(tbl[i].mode, tbl[i].data);
      in_valid = 1'b0;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!out_valid && t < 10);
      if (!out_valid) begin
        chk("tbl_timeout", 0, 1);
      end else begin
        chk("tbl_out_data", out_data, tbl[i].exp_data);
        chk("tbl_out_sat", out_sat, tbl[i].exp_sat);
        chk("tbl_out_mode", out_mode, tbl[i].mode);
      end
      @(posedge clk);
      #1;
    end
    drain();

    // Mode interleave on consecutive cycles
    got_q.delete();
    for (int i = 0; i < 4; i++) send(2'(i), 16'd256);
    drain();
    chk("interleave_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("interleave_data", got_q[i].data, il_exp[i]);
        chk("interleave_mode", got_q[i].mode, i);
      end
    end

    // Back-to-back inputs with downstream stalled for 5 cycles
    chk_lat = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vals[i]   = 16'($urandom_range(0, 16'hFFFF));
      vmodes[i] = 2'($urandom_range(0, 3));
    end
    base      = n_out;
    out_ready = 1'b0;
    idx       = 0;
    stalled   = 0;
    saw_low   = 1'b0;
    in_valid  = 1'b1;
    in_mode   = vmodes[0];
    in_data   = vals[0];
    for (int c = 0; c < 60 && in_valid; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (!in_ready) saw_low = 1'b1;
      if (out_valid && !out_ready) stalled++;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 10) begin
          in_mode = vmodes[idx];
          in_data = vals[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (stalled >= 5) out_ready = 1'b1;
    end
    chk("stall_all_accepted", idx, 10);
    drain();
    chk("stall_in_ready_low", saw_low, 1);
    chk("stall_out_count", n_out - base, 10);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_mode   = 2'($urandom_range(0, 3));
      in_data   = 16'($urandom_range(0, 16'hFFFF) >> $urandom_range(0, 8));
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    drain();

    // Reset with two samples in flight
    chk_lat   = 1'b1;
    out_ready = 1'b1;
    send(2'd0, 16'd256);
    send(2'd1, 16'd768);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_conv_count", conv_count, 0);
    chk("midrst_out_data", out_data, 0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_stale", seen, 0);
    @(posedge clk);
    #1;

    // Counter wrap
    out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) send(2'($urandom_range(0, 3)), 16'($urandom_range(0, 4095)));
    drain();
    chk("wrap_pre", conv_count, 65535);
    send(2'd0, 16'd256);
    drain();
    chk("wrap_post", conv_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
